// File: rtl/dot_result_drain.sv
// dot_result_drain
//   Waits LAT cycles after a start pulse for the upstream dot-product engines
//   to settle. It then snapshots all N lane results and streams them one lane
//   per beat over a valid/ready port while summing them. After the last beat
//   it publishes the sum on 'total' with a one-cycle 'done' pulse.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle pulse: upstream engines began a new computation
//   c_in       N lane results, lane i at c_in[i*36 +: 36]
//   out_ready  downstream accepts the current beat
//   out_valid  out_data / out_idx / out_last are valid
//   out_data   result of lane out_idx
//   out_idx    lane number of out_data
//   out_last   marks the beat of lane N-1
//   total      sum of all lanes of the last completed drain
//   done       one-cycle pulse when total is updated
//   busy       high whenever the FSM is not idle
//   overrun    sticky: a start arrived while busy (cleared only by rst)

module dot_result_drain #(
  parameter int N   = 4,
  parameter int LAT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N*36-1:0]              c_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [35:0]                  out_data,
  output logic [$clog2(N)-1:0]         out_idx,
  output logic                         out_last,
  output logic [36+$clog2(N)-1:0]      total,
  output logic                         done,
  output logic                         busy,
  output logic                         overrun
);

  localparam int IW = $clog2(N);
  localparam int AW = 36 + IW;
  // One extra bit so that LAT = 1 still gets a non-zero-width counter.
  localparam int CW = $clog2(LAT + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    FIN
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   acc;
  logic [35:0]     shadow [N];

  logic [AW-1:0]   acc_next;
  logic [IW-1:0]   idx_next;

  // Lanes are zero-extended into the wider accumulator, so N full-scale
  // lanes can never wrap.
  assign acc_next = acc + AW'(shadow[idx]);
  assign idx_next = idx + IW'(1);

  assign out_idx  = idx;
  assign busy     = (state != IDLE);

  // Main control FSM. The shadow registers decouple the stream from c_in:
  // once captured, upstream may change c_in freely. The beat outputs are
  // reloaded only on a transfer, so they hold steady while out_ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      total     <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      if (start && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == CNT_END) begin
            for (int i = 0; i < N; i++) begin
              shadow[i] <= c_in[i*36 +: 36];
            end
            idx       <= '0;
            acc       <= '0;
            out_data  <= c_in[35:0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= SEND;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        SEND: begin
          if (out_ready) begin
            acc <= acc_next;
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              total     <= acc_next;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              idx      <= idx_next;
              out_data <= shadow[idx_next];
              out_last <= (idx_next == LAST_IDX);
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_result_drain.sv
// tb_dot_result_drain
//   Scoreboard bench for dot_result_drain (N=4, LAT=8). The driver pushes
//   the expected lane stream and lane sum of each drain into queues; an
//   independent monitor pops and compares whenever a beat transfers or done
//   pulses. Directed scenarios cover latency, full-scale sums, stalls, input
//   changes after capture, overrun and mid-drain reset. A randomized phase
//   uses random lanes and random out_ready.

module tb_dot_result_drain;

  localparam int N   = 4;
  localparam int LAT = 8;
  localparam int IW  = $clog2(N);
  localparam int AW  = 36 + IW;

  logic              clk;
  logic              rst;
  logic              start;
  logic [N*36-1:0]   c_in;
  logic              out_ready;
  logic              out_valid;
  logic [35:0]       out_data;
  logic [IW-1:0]     out_idx;
  logic              out_last;
  logic [AW-1:0]     total;
  logic              done;
  logic              busy;
  logic              overrun;

  typedef struct {
    logic [35:0]   data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t             beatQ[$];
  logic [AW-1:0]     totalQ[$];
  logic [AW-1:0]     lastTotal;

  int                vectors;
  int                errors;
  bit                readyRandom;

  dot_result_drain #(.N(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .c_in      (c_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .total     (total),
    .done      (done),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs beyond every local bound.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] randLane();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) == 0) return '1;
    return r[35:0];
  endfunction

  function automatic logic [N*36-1:0] randLanes();
    logic [N*36-1:0] f;
    for (int i = 0; i < N; i++) f[i*36 +: 36] = randLane();
    return f;
  endfunction

  // Issues one start with the given lanes and queues the expected stream.
  // Must be called at posedge+1 with the DUT idle. Returns at capture+1,
  // after replacing c_in with 'after' to prove capture isolation.
  task automatic applyStimulus(input logic [N*36-1:0] lanes,
                               input logic [N*36-1:0] after);
    beat_t       b;
    logic [AW-1:0] sum;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      b.data = lanes[i*36 +: 36];
      b.idx  = IW'(i);
      b.last = (i == N - 1);
      beatQ.push_back(b);
      sum = sum + AW'(lanes[i*36 +: 36]);
    end
    totalQ.push_back(sum);
    lastTotal = sum;
    c_in  = lanes;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (LAT) @(posedge clk);
    #1 c_in = after;
  endtask

  // Counts edges until done is seen (sampled 1 after each edge).
  task automatic waitDone(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(posedge clk);
      #1 cyc++;
      if (done) break;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
  endtask

  // Random backpressure source, active only when the bench requests it.
  always @(posedge clk) begin
    #1;
    if (readyRandom) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares transferred beats and done/total against the queues,
  // and checks that a stalled beat holds steady until it is accepted.
  beat_t heldBeat;
  bit    holdValid;

  always @(negedge clk) begin
    if (rst) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid) begin
        checkOutput("stall_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_data", 64'(out_data), 64'(heldBeat.data));
        checkOutput("stall_idx", 64'(out_idx), 64'(heldBeat.idx));
        checkOutput("stall_last", 64'(out_last), 64'(heldBeat.last));
      end
      holdValid     = out_valid && !out_ready;
      heldBeat.data = out_data;
      heldBeat.idx  = out_idx;
      heldBeat.last = out_last;

      if (out_valid && out_ready) begin
        if (beatQ.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got idx %0d data %0h, expected no beat",
                   out_idx, out_data);
        end else begin
          beat_t e;
          e = beatQ.pop_front();
          checkOutput("beat_data", 64'(out_data), 64'(e.data));
          checkOutput("beat_idx", 64'(out_idx), 64'(e.idx));
          checkOutput("beat_last", 64'(out_last), 64'(e.last));
        end
      end

      if (done) begin
        checkOutput("done_valid_low", 64'(out_valid), 64'd0);
        if (totalQ.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL unexpected_done: got total %0h, expected no done", total);
        end else begin
          checkOutput("total", 64'(total), 64'(totalQ.pop_front()));
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_out_data"}, 64'(out_data), 64'd0);
    checkOutput({tag, "_out_idx"}, 64'(out_idx), 64'd0);
    checkOutput({tag, "_out_last"}, 64'(out_last), 64'd0);
    checkOutput({tag, "_total"}, 64'(total), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    int              cyc;
    int              viol;
    logic [N*36-1:0] lanes;

    vectors     = 0;
    errors      = 0;
    readyRandom = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    c_in        = '0;
    out_ready   = 1'b1;

    repeat (2) @(posedge clk);
    #1 checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic latency and sum, lanes 1000..4000.
    $display("[TB] basic drain");
    applyStimulus({36'd4000, 36'd3000, 36'd2000, 36'd1000}, '0);
    waitDone(50, cyc);
    checkOutput("start_to_done", 64'(LAT + cyc), 64'(LAT + N));
    checkOutput("total_basic", 64'(total), 64'd10000);

    // Start in the idle cycle right after FIN, full-scale lanes.
    $display("[TB] back-to-back full-scale drain");
    @(posedge clk);
    #1 applyStimulus({N{36'hF_FFFF_FFFF}}, '0);
    waitDone(50, cyc);
    checkOutput("b2b_start_to_done", 64'(LAT + cyc), 64'(LAT + N));
    checkOutput("total_fullscale", 64'(total), 64'h3F_FFFF_FFFC);

    // Five stalled cycles while lane 1 is presented.
    $display("[TB] stall during lane 1");
    @(posedge clk);
    #1 lanes = randLanes();
    applyStimulus(lanes, randLanes());
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("stall_lane1_idx", 64'(out_idx), 64'd1);
    checkOutput("stall_lane1_data", 64'(out_data), 64'(lanes[36 +: 36]));
    out_ready = 1'b1;
    waitDone(50, cyc);
    checkOutput("stall_delay", 64'(6 + cyc), 64'(N + 5));

    // Second start while streaming: flagged, otherwise ignored.
    $display("[TB] overrun");
    @(posedge clk);
    #1 checkOutput("overrun_before", 64'(overrun), 64'd0);
    applyStimulus(randLanes(), '0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("overrun_set", 64'(overrun), 64'd1);
    waitDone(50, cyc);
    viol = 0;
    repeat (LAT + N + 4) begin
      @(posedge clk);
      #1 if (busy || out_valid) viol++;
    end
    checkOutput("no_new_wait", 64'(viol), 64'd0);
    checkOutput("overrun_sticky", 64'(overrun), 64'd1);

    // Reset while lane 2 is presented: abort with no done.
    $display("[TB] reset mid-drain");
    applyStimulus(randLanes(), randLanes());
    repeat (2) @(posedge clk);
    #1 checkOutput("pre_rst_idx", 64'(out_idx), 64'd2);
    rst = 1'b1;
    #1 checkAllZero("midrst");
    beatQ.delete();
    totalQ.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    viol = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done || busy) viol++;
    end
    checkOutput("no_done_after_rst", 64'(viol), 64'd0);
    applyStimulus({36'd7, 36'd5, 36'd3, 36'd1}, '0);
    waitDone(50, cyc);
    checkOutput("total_after_rst", 64'(total), 64'd16);

    // Randomized drains with random backpressure and idle gaps.
    $display("[TB] random drains");
    readyRandom = 1'b1;
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 applyStimulus(randLanes(), randLanes());
      waitDone(400, cyc);
    end
    readyRandom = 1'b0;
    out_ready   = 1'b1;

    // total holds after the last drain.
    repeat (6) @(posedge clk);
    #1 checkOutput("total_hold", 64'(total), 64'(lastTotal));
    checkOutput("beat_queue_empty", 64'(beatQ.size()), 64'd0);
    checkOutput("total_queue_empty", 64'(totalQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dot_result_drain.md
DOT_RESULT_DRAIN -- requirements
Module: dot_result_drain

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of parallel dot-product lanes (N >= 2).
REQ-002 The block SHALL have parameter LAT, default 8, giving the number of cycles the upstream engine needs after a start before its results are final (LAT >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle pulse marking that the upstream engines began a new computation.
REQ-006 The block SHALL have port c_in, input, N*36 bits, the lane results; lane i is c_in[i*36 +: 36].
REQ-007 The block SHALL have port out_ready, input, 1 bit, the downstream acceptance signal.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning out_data, out_idx and out_last are valid.
REQ-009 The block SHALL have port out_data, output, 36 bits, the result of the current lane.
REQ-010 The block SHALL have port out_idx, output, clog2(N) bits, the lane number of out_data.
REQ-011 The block SHALL have port out_last, output, 1 bit, high with out_valid when out_idx == N-1.
REQ-012 The block SHALL have port total, output, 36+clog2(N) bits, the sum of all lane results of the last completed drain.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse when total is updated.
REQ-014 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-015 The block SHALL have port overrun, output, 1 bit, a sticky flag for a start received while busy.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT, SEND and FIN, with IDLE as the reset state.
REQ-017 In IDLE, start=1 SHALL clear the wait counter and move the FSM to WAIT; start=0 SHALL keep it in IDLE.
REQ-018 In WAIT, the counter SHALL increment every cycle; on the edge where counter == LAT-1, the block SHALL copy all N lanes of c_in into shadow registers, clear idx and the accumulator, and move to SEND.
REQ-019 The c_in capture SHALL therefore happen on the LAT-th rising edge after the edge that sampled start, and c_in changes after the capture SHALL NOT affect the outputs.
REQ-020 In SEND, out_valid SHALL be 1, out_data SHALL equal shadow[idx], and out_idx SHALL equal idx.
REQ-021 Once out_valid is high with out_ready low, out_data, out_idx and out_last SHALL hold stable.
REQ-022 A beat SHALL transfer on every edge with out_valid & out_ready; the block SHALL add shadow[idx] to the accumulator and increment idx.
REQ-023 Back-to-back transfers SHALL run at one lane per cycle while out_ready stays high.
REQ-024 The transfer with out_last=1 SHALL move the FSM to FIN.
REQ-025 In FIN, for exactly one cycle, done SHALL be 1, total SHALL equal the final accumulator value, and out_valid SHALL be 0; the FSM SHALL then return to IDLE.
REQ-026 total SHALL hold its value until the next FIN.
REQ-027 The accumulator SHALL be 36+clog2(N) bits wide, zero-extend each lane, and never overflow.
REQ-028 A start in WAIT, SEND or FIN SHALL be ignored for data purposes and SHALL set overrun=1; overrun SHALL clear only on rst.
REQ-029 A start in the IDLE cycle that directly follows FIN SHALL be accepted normally, with no idle gap required.
REQ-030 The minimum start-to-done time SHALL be LAT+N+1 cycles, with out_ready held high.

Reset
REQ-031 rst=1 SHALL force IDLE and set out_valid=0, out_data=0, out_idx=0, out_last=0, total=0, done=0, busy=0, overrun=0, clearing all counters, shadows and the accumulator.
REQ-032 rst asserted mid-WAIT or mid-SEND SHALL abort the drain immediately; no done pulse and no total update SHALL follow.
REQ-033 After rst deasserts, the block SHALL require a fresh start.

Verification (N=4, LAT=8)
REQ-034 Scenario: start at edge E0, lanes {1000, 2000, 3000, 4000}, out_ready=1 -> capture at E8; beats idx 0..3 on E9..E12 with out_last on idx 3; done=1 with total=10000 in the cycle after E12.
REQ-035 Scenario: lanes all 36'hF_FFFF_FFFF -> total = 4 * (2^36-1) = 38'h3F_FFFF_FFFC, with no wrap.
REQ-036 Scenario: out_ready low for 5 cycles during idx 1 -> out_data stays equal to lane1 throughout, no beat is lost or duplicated, and done is delayed by 5 cycles.
REQ-037 Scenario: c_in changes to 0 one cycle after capture -> the streamed values and total still equal the pre-change values.
REQ-038 Scenario: second start during SEND -> overrun=1, the current drain completes unchanged, and the FSM returns to IDLE without a new WAIT.
REQ-039 Scenario: rst pulse during idx 2 of SEND -> all outputs are zero in the same cycle, no done pulse follows, and a new start then drains correctly.
